// File: rtl/ucsbece152a_updown_modcounter.sv
// ucsbece152a_updown_modcounter: up/down modulo counter with wrap, saturate and one-shot modes
module ucsbece152a_updown_modcounter #(
  parameter int WIDTH = 3,
  parameter int MAX = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             done_o
);
  typedef enum logic {RUN, DONE} state_e;
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  state_e           state_q, state_d;
  logic             step;
  assign count_o = count_q;
  assign wrap_o = wrap_q;
  assign done_o = state_q == DONE;
  assign tc_o = dir_i ? count_q == '0 : count_q == MAX_V;
  assign step = enable_i && state_q == RUN;
  // next state: load > DONE-hold > enable; terminal behaviour chosen by mode (11 behaves as wrap)
  always_comb begin
    count_d = count_q;
    wrap_d = 1'b0;
    state_d = state_q;
    if (load_i) begin
      count_d = load_val_i > MAX_V ? MAX_V : load_val_i;
      state_d = RUN;
    end else if (step && !tc_o) begin
      count_d = dir_i ? count_q - ONE : count_q + ONE;
    end else if (step && mode_i == 2'b10) begin
      state_d = DONE;
    end else if (step && mode_i != 2'b01) begin
      count_d = dir_i ? MAX_V : '0;
      wrap_d = 1'b1;
    end
  end
  // state register with synchronous reset overriding every control
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q <= 1'b0;
      state_q <= RUN;
    end else begin
      count_q <= count_d;
      wrap_q <= wrap_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_ucsbece152a_updown_modcounter.sv
// tb_ucsbece152a_updown_modcounter: scoreboard bench comparing MAX=7 and MAX=5 counters to a reference model
module tb_ucsbece152a_updown_modcounter;
  logic clk = 1'b0;
  logic rst = 1'b1, enable_i = 1'b0, dir_i = 1'b0, load_i = 1'b0;
  logic [2:0] load_val_i = '0;
  logic [1:0] mode_i = '0;
  logic [2:0] count_a, count_b;
  logic tc_a, tc_b, wrap_a, wrap_b, done_a, done_b;
  int n_checks = 0, n_fail = 0;
  typedef struct {int c; bit w; bit d;} st_t;
  typedef struct {st_t a; st_t b; bit ta; bit tb;} exp_t;
  exp_t q[$];
  st_t sa, sb;

  always #5 clk = ~clk;

  ucsbece152a_updown_modcounter dut_a (
    .clk(clk), .rst(rst), .enable_i(enable_i), .dir_i(dir_i), .load_i(load_i),
    .load_val_i(load_val_i), .mode_i(mode_i), .count_o(count_a), .tc_o(tc_a),
    .wrap_o(wrap_a), .done_o(done_a)
  );
  ucsbece152a_updown_modcounter #(.WIDTH(3), .MAX(5)) dut_b (
    .clk(clk), .rst(rst), .enable_i(enable_i), .dir_i(dir_i), .load_i(load_i),
    .load_val_i(load_val_i), .mode_i(mode_i), .count_o(count_b), .tc_o(tc_b),
    .wrap_o(wrap_b), .done_o(done_b)
  );

  function automatic st_t nxt(st_t s, int max, bit r, bit ld, int lv, bit en, bit dn, int mode);
    st_t n = s;
    n.w = 0;
    if (r) begin
      n.c = 0;
      n.d = 0;
    end else if (ld) begin
      n.c = lv > max ? max : lv;
      n.d = 0;
    end else if (!s.d && en) begin
      if (!dn && s.c < max) n.c = s.c + 1;
      else if (dn && s.c > 0) n.c = s.c - 1;
      else if (mode == 1) n.c = s.c;
      else if (mode == 2) n.d = 1;
      else begin
        n.c = dn ? max : 0;
        n.w = 1;
      end
    end
    return n;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit r, bit ld, int lv, bit en, bit dn, int mode);
    exp_t e;
    rst = r; load_i = ld; load_val_i = 3'(lv); enable_i = en; dir_i = dn; mode_i = 2'(mode);
    @(posedge clk);
    sa = nxt(sa, 7, r, ld, lv, en, dn, mode);
    sb = nxt(sb, 5, r, ld, lv, en, dn, mode);
    e.a = sa;
    e.b = sb;
    e.ta = dn ? sa.c == 0 : sa.c == 7;
    e.tb = dn ? sb.c == 0 : sb.c == 5;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // monitor: every settled cycle pops the expected response and compares both instances
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("count_a", int'(count_a), e.a.c);
      chk("wrap_a", int'(wrap_a), int'(e.a.w));
      chk("done_a", int'(done_a), int'(e.a.d));
      chk("tc_a", int'(tc_a), int'(e.ta));
      chk("count_b", int'(count_b), e.b.c);
      chk("wrap_b", int'(wrap_b), int'(e.b.w));
      chk("done_b", int'(done_b), int'(e.b.d));
      chk("tc_b", int'(tc_b), int'(e.tb));
    end
  end

  initial begin
    sa = '{0, 0, 0};
    sb = '{0, 0, 0};
    @(negedge clk);
    #1;
    repeat (2) step(1, 1, 5, 1, 0, 0);
    chk("reset_count", int'(count_a), 0);
    chk("reset_done", int'(done_a), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 0);
    chk("wrap_up_end", int'(count_a), 2);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    chk("wrap_down", int'(count_a), 7);
    chk("wrap_down_pulse", int'(wrap_a), 1);
    step(0, 1, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 1, 1, 1);
    chk("sat_down", int'(count_a), 0);
    chk("sat_no_wrap", int'(wrap_a), 0);
    step(0, 1, 7, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    chk("sat_up", int'(count_a), 7);
    step(0, 1, 4, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    chk("hold", int'(count_a), 4);
    step(0, 1, 6, 0, 0, 0);
    chk("load_clamp", int'(count_b), 5);
    step(0, 1, 2, 1, 0, 0);
    chk("load_over_en", int'(count_a), 2);
    step(0, 1, 5, 0, 0, 2);
    repeat (3) step(0, 0, 0, 1, 0, 2);
    chk("oneshot_count", int'(count_a), 7);
    chk("oneshot_done", int'(done_a), 1);
    repeat (3) step(0, 0, 0, 1, 1, 0);
    chk("done_hold", int'(count_a), 7);
    step(0, 1, 2, 0, 0, 2);
    chk("done_exit", int'(done_a), 0);
    step(0, 1, 7, 0, 0, 2);
    step(0, 0, 0, 1, 0, 2);
    step(1, 0, 0, 1, 0, 2);
    chk("rst_in_done", int'(done_a), 0);
    step(0, 0, 0, 1, 0, 0);
    chk("after_rst", int'(count_a), 1);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(49) == 0, $urandom_range(7) == 0, int'($urandom_range(7)),
           $urandom_range(3) != 0, 1'($urandom_range(1)), int'($urandom_range(3)));
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
